// File: rtl/cae_row_window_buffer_if.sv
// Row-in / window-out handshake bundle for the CAE 3-row window buffer.
// slave = the buffer itself, master = the row producer / window consumer side.
interface cae_row_window_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 28,
    parameter int FRAME_ROWS = 28,
    parameter int IDX_W      = $clog2(FRAME_ROWS + 1)
);
    localparam int ROW_W = ROW_LEN * DATA_WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic             win_valid;
    logic             win_ready;
    logic [ROW_W-1:0] win_row1;
    logic [ROW_W-1:0] win_row2;
    logic [ROW_W-1:0] win_row3;
    logic [IDX_W-1:0] win_idx;
    logic             win_last;
    logic             frame_done;

    modport master (
        output in_valid, in_row, win_ready,
        input  in_ready, win_valid, win_row1, win_row2, win_row3, win_idx, win_last, frame_done
    );

    modport slave (
        input  in_valid, in_row, win_ready,
        output in_ready, win_valid, win_row1, win_row2, win_row3, win_idx, win_last, frame_done
    );
endinterface

// File: rtl/cae_row_window_buffer.sv
// 3-row sliding window line buffer (valid / zero-padded same mode); window registered 1 cycle after the triggering row.
// Backpressure: in_ready drops while an unconsumed window blocks the output slot; the held window stays stable.
module cae_row_window_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_LEN    = 28,
    parameter int FRAME_ROWS = 28,
    parameter int IDX_W      = $clog2(FRAME_ROWS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pad_mode,
    cae_row_window_buffer_if.slave bus
);
    localparam int ROW_W = ROW_LEN * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_ROW       = IDX_W'(FRAME_ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX_VALID = IDX_W'(FRAME_ROWS - 3);
    localparam logic [IDX_W-1:0] LAST_IDX_SAME  = IDX_W'(FRAME_ROWS - 1);

    if (FRAME_ROWS < 3) begin : g_bad_frame_rows
        $error("cae_row_window_buffer: FRAME_ROWS must be >= 3");
    end

    typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DRAIN} state_t;
    typedef logic [ROW_W-1:0] row_t;

    state_t           state_q, state_d;
    row_t             r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [IDX_W-1:0] rows_in_q, rows_in_d;
    logic             pad_q, pad_d;
    logic             win_valid_q, win_valid_d;
    row_t             win_row1_q, win_row1_d, win_row2_q, win_row2_d, win_row3_q, win_row3_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic             win_last_q, win_last_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_free, consume, in_ready_w, accept, last_row;
    logic             shift, emit, first_win;
    row_t             shift_row;
    logic [IDX_W-1:0] rows_in_inc, thresh;

    assign slot_free   = !win_valid_q || bus.win_ready;
    assign consume     = win_valid_q && bus.win_ready;
    assign in_ready_w  = enable && ((state_q == IDLE) || (state_q == FILL) ||
                                    ((state_q == STREAM) && slot_free));
    assign accept      = bus.in_valid && in_ready_w;
    assign rows_in_inc = rows_in_q + IDX_W'(1);
    assign last_row    = (rows_in_q == LAST_ROW);
    // Same mode starts one row earlier: the cleared r0 stands in for the top pad row.
    assign thresh      = pad_q ? IDX_W'(2) : IDX_W'(3);

    always_comb begin
        state_d      = state_q;
        r0_d         = r0_q;
        r1_d         = r1_q;
        r2_d         = r2_q;
        rows_in_d    = rows_in_q;
        pad_d        = pad_q;
        win_valid_d  = win_valid_q && !consume;
        win_row1_d   = win_row1_q;
        win_row2_d   = win_row2_q;
        win_row3_d   = win_row3_q;
        win_idx_d    = win_idx_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;
        shift        = 1'b0;
        shift_row    = '0;
        emit         = 1'b0;
        first_win    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift     = 1'b1;
                    shift_row = bus.in_row;
                    rows_in_d = IDX_W'(1);
                    pad_d     = pad_mode;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    shift     = 1'b1;
                    shift_row = bus.in_row;
                    rows_in_d = rows_in_inc;
                    if (rows_in_inc == thresh) begin
                        emit      = 1'b1;
                        first_win = 1'b1;
                        state_d   = last_row ? (pad_q ? FLUSH : DRAIN) : STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    shift     = 1'b1;
                    shift_row = bus.in_row;
                    rows_in_d = rows_in_inc;
                    emit      = 1'b1;
                    if (last_row) begin
                        state_d = pad_q ? FLUSH : DRAIN;
                    end
                end
            end
            FLUSH: begin
                // Bottom pad: shift a zero row in to form the final window.
                if (enable && slot_free) begin
                    shift   = 1'b1;
                    emit    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (consume && win_last_q) begin
                    state_d      = IDLE;
                    r0_d         = '0;
                    r1_d         = '0;
                    r2_d         = '0;
                    rows_in_d    = '0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (shift) begin
            r0_d = r1_q;
            r1_d = r2_q;
            r2_d = shift_row;
        end

        if (emit) begin
            win_valid_d = 1'b1;
            win_row1_d  = r0_d;
            win_row2_d  = r1_d;
            win_row3_d  = r2_d;
            win_idx_d   = first_win ? '0 : (win_idx_q + IDX_W'(1));
            win_last_d  = (win_idx_d == (pad_q ? LAST_IDX_SAME : LAST_IDX_VALID));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q      <= IDLE;
            r0_q         <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            rows_in_q    <= '0;
            pad_q        <= 1'b0;
            win_valid_q  <= 1'b0;
            win_row1_q   <= '0;
            win_row2_q   <= '0;
            win_row3_q   <= '0;
            win_idx_q    <= '0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            rows_in_q    <= rows_in_d;
            pad_q        <= pad_d;
            win_valid_q  <= win_valid_d;
            win_row1_q   <= win_row1_d;
            win_row2_q   <= win_row2_d;
            win_row3_q   <= win_row3_d;
            win_idx_q    <= win_idx_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row1   = win_row1_q;
    assign bus.win_row2   = win_row2_q;
    assign bus.win_row3   = win_row3_q;
    assign bus.win_idx    = win_idx_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_cae_row_window_buffer.sv
// Bench for cae_row_window_buffer: frame-level window model, vector table, hand corner sequences, random traffic.
module tb_cae_row_window_buffer;
    localparam int DW    = 8;
    localparam int RL    = 4;
    localparam int FR    = 5;
    localparam int IW    = $clog2(FR + 1);
    localparam int ROW_W = DW * RL;

    typedef logic [ROW_W-1:0] row_t;
    typedef struct {
        row_t a;
        row_t b;
        row_t c;
        int   idx;
        bit   last;
    } win_t;
    typedef struct {
        logic pad;
        int   base;
        int   exp_n;
        int   f1, f2, f3;
        int   l1, l2, l3;
    } vec_t;

    logic clk;
    logic rst;
    logic enable;
    logic pad_mode;

    cae_row_window_buffer_if #(.DATA_WIDTH(DW), .ROW_LEN(RL), .FRAME_ROWS(FR), .IDX_W(IW)) bus ();

    cae_row_window_buffer #(.DATA_WIDTH(DW), .ROW_LEN(RL), .FRAME_ROWS(FR), .IDX_W(IW)) dut (
        .clk_i    (clk),
        .rst      (rst),
        .enable   (enable),
        .pad_mode (pad_mode),
        .bus      (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   fd_count = 0;
    int   frames_pushed = 0;
    bit   fd_due = 0;
    bit   hold_vld = 0;
    bit   rand_rdy = 0;
    bit   rdy_level = 1;
    logic [IW+3*ROW_W:0] held_v;
    win_t exp_q[$];
    win_t got_q[$];
    row_t cur_rows[FR];
    vec_t vecs[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    function automatic row_t row_of(input logic [7:0] v);
        return {RL{v}};
    endfunction

    function automatic void fill_rows(input int base);
        for (int k = 0; k < FR; k++) cur_rows[k] = row_of(8'(base + k));
    endfunction

    // Expected windows straight from the definition: slide a 3-row view over the (optionally zero-framed) rows.
    function automatic void model_push(input logic pad);
        row_t seq[$];
        int   n;
        if (pad) seq.push_back('0);
        for (int k = 0; k < FR; k++) seq.push_back(cur_rows[k]);
        if (pad) seq.push_back('0);
        n = seq.size() - 2;
        for (int i = 0; i < n; i++) exp_q.push_back('{seq[i], seq[i+1], seq[i+2], i, (i == n - 1)});
        frames_pushed++;
    endfunction

    // Sole driver of win_ready; runs after the main process's posedge+1 updates.
    initial begin
        bus.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.win_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 0;
            fd_due   = 0;
        end else begin
            if (fd_due) begin
                check("frame_done_pulse", bus.frame_done, 1);
                fd_due = 0;
            end else begin
                check("frame_done_idle", bus.frame_done, 0);
            end
            if (bus.frame_done) fd_count++;
            if (hold_vld)
                check("stall_stable", {bus.win_valid, bus.win_row1, bus.win_row2, bus.win_row3, bus.win_idx, bus.win_last},
                      {1'b1, held_v});
            if (bus.win_valid && bus.win_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_window: got idx %0d, expected no window", bus.win_idx);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    check("win_rows", {bus.win_row1, bus.win_row2, bus.win_row3}, {e.a, e.b, e.c});
                    check("win_idx", bus.win_idx, e.idx);
                    check("win_last", bus.win_last, e.last);
                end
                got_q.push_back('{bus.win_row1, bus.win_row2, bus.win_row3, int'(bus.win_idx), bus.win_last});
                if (bus.win_last) fd_due = 1;
            end
            hold_vld = bus.win_valid && !bus.win_ready;
            held_v   = {bus.win_row1, bus.win_row2, bus.win_row3, bus.win_idx, bus.win_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a row and returns at posedge+1 after it was accepted; in_valid stays high.
    task automatic send_row(input row_t r);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = r;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected accept", n);
                break;
            end
        end
        tick();
    endtask

    task automatic send_frame(input logic pad, input bit rnd);
        model_push(pad);
        pad_mode = pad;
        for (int k = 0; k < FR; k++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                enable = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) tick();
                enable = 1'b1;
            end
            send_row(cur_rows[k]);
            if (k == 0) pad_mode = ~pad;
        end
        bus.in_valid = 1'b0;
        if (rnd && $urandom_range(0, 1) == 1) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            enable = 1'b1;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || fd_due) && n < 600) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        pad_mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        vecs[0] = '{1'b0, 1,   3, 1, 2, 3,     3,   4,   5};
        vecs[1] = '{1'b1, 1,   5, 0, 1, 2,     4,   5,   0};
        vecs[2] = '{1'b0, 16,  3, 16, 17, 18,  18,  19,  20};
        vecs[3] = '{1'b1, 240, 5, 0, 240, 241, 243, 244, 0};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_rows", {bus.win_row1, bus.win_row2, bus.win_row3}, 0);
        check("rst_win_idx", bus.win_idx, 0);
        check("rst_win_last", bus.win_last, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        tick();
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        tick();

        // Valid mode: first window appears the cycle after the 3rd accept
        fill_rows(1);
        model_push(1'b0);
        pad_mode = 1'b0;
        for (int k = 0; k < FR; k++) begin
            send_row(cur_rows[k]);
            bus.in_valid = 1'b0;
            @(negedge clk);
            check("fill_win_valid", bus.win_valid, (k >= 2));
            tick();
        end
        wait_done();

        // Vector table: whole frames with a free consumer
        for (int i = 0; i < 4; i++) begin
            int fd0;
            fd0 = fd_count;
            got_q.delete();
            fill_rows(vecs[i].base);
            send_frame(vecs[i].pad, 1'b0);
            wait_done();
            check("tbl_count", got_q.size(), vecs[i].exp_n);
            check("tbl_first", {got_q[0].a, got_q[0].b, got_q[0].c},
                  {row_of(8'(vecs[i].f1)), row_of(8'(vecs[i].f2)), row_of(8'(vecs[i].f3))});
            check("tbl_last", {got_q[got_q.size()-1].a, got_q[got_q.size()-1].b, got_q[got_q.size()-1].c},
                  {row_of(8'(vecs[i].l1)), row_of(8'(vecs[i].l2)), row_of(8'(vecs[i].l3))});
            check("tbl_frame_done", fd_count - fd0, 1);
        end

        // Consumer stall after window 0: input side must block
        fill_rows(1);
        model_push(1'b0);
        pad_mode = 1'b0;
        for (int k = 0; k < 3; k++) send_row(cur_rows[k]);
        rdy_level  = 1'b0;
        bus.in_row = cur_rows[3];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_win_valid", bus.win_valid, 1);
            tick();
        end
        rdy_level = 1'b1;
        send_row(cur_rows[3]);
        send_row(cur_rows[4]);
        bus.in_valid = 1'b0;
        wait_done();

        // enable low mid-STREAM and during FLUSH (same mode)
        fill_rows(1);
        model_push(1'b1);
        pad_mode = 1'b1;
        for (int k = 0; k < 3; k++) send_row(cur_rows[k]);
        bus.in_row = cur_rows[3];
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("en_stream_in_ready", bus.in_ready, 0);
            if (c > 0) check("en_stream_no_emit", bus.win_valid, 0);
            tick();
        end
        enable = 1'b1;
        send_row(cur_rows[3]);
        send_row(cur_rows[4]);
        bus.in_valid = 1'b0;
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) check("en_flush_no_emit", bus.win_valid, 0);
            tick();
        end
        enable = 1'b1;
        wait_done();

        // Reset after the second row: partial frame vanishes without frame_done
        fill_rows(7);
        pad_mode = 1'b0;
        send_row(cur_rows[0]);
        send_row(cur_rows[1]);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_win_valid", bus.win_valid, 0);
        check("midrst_win_rows", {bus.win_row1, bus.win_row2, bus.win_row3}, 0);
        check("midrst_frame_done", bus.frame_done, 0);
        tick();
        rst = 1'b0;
        got_q.delete();
        fill_rows(1);
        send_frame(1'b0, 1'b0);
        wait_done();
        check("postrst_win0", {got_q[0].a, got_q[0].b, got_q[0].c}, {row_of(8'd1), row_of(8'd2), row_of(8'd3)});

        // Two frames back to back, valid then same, pad_mode toggled inside each
        got_q.delete();
        fill_rows(1);
        send_frame(1'b0, 1'b0);
        fill_rows(64);
        send_frame(1'b1, 1'b0);
        wait_done();
        check("b2b_count", got_q.size(), 8);
        check("b2b_idx_restart", got_q[3].idx, 0);

        // Random traffic against the model
        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            logic pad;
            pad = 1'($urandom_range(0, 1));
            for (int k = 0; k < FR; k++) cur_rows[k] = row_t'($urandom);
            send_frame(pad, 1'b1);
            if ($urandom_range(0, 2) == 0) wait_done();
        end
        wait_done();
        rand_rdy = 1'b0;
        repeat (3) tick();
        check("frames_done_total", fd_count, frames_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
